// File: rtl/video_bus_arb.sv
// Round-robin arbiter sharing the video block's single register/VRAM access port
// between two valid/ready requesters, with a one-cycle read response strobe per port.
module video_bus_arb #(
   parameter int unsigned ADDR_W = 13,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned RD_LAT = 1
) (
   input  logic              clk,
   input  logic              NRST,
   input  logic              req_valid_0,
   output logic              req_ready_0,
   input  logic              req_we_0,
   input  logic              req_ctl_0,
   input  logic [ADDR_W-1:0] req_addr_0,
   input  logic [DATA_W-1:0] req_wdata_0,
   output logic              rsp_valid_0,
   output logic [DATA_W-1:0] rsp_data_0,
   input  logic              req_valid_1,
   output logic              req_ready_1,
   input  logic              req_we_1,
   input  logic              req_ctl_1,
   input  logic [ADDR_W-1:0] req_addr_1,
   input  logic [DATA_W-1:0] req_wdata_1,
   output logic              rsp_valid_1,
   output logic [DATA_W-1:0] rsp_data_1,
   output logic              sel_ram,
   output logic              sel_ctl,
   output logic              we,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] din,
   input  logic [DATA_W-1:0] ram_dout,
   input  logic [DATA_W-1:0] ctl_dout
);

   localparam int unsigned CNT_W = $clog2(RD_LAT + 1);

   typedef enum logic [1:0] {StIdle, StIssue, StRdWait} state_e;

   state_e             state_q, state_d;
   logic               prio_q, gnt_q, we_q, ctl_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               gnt, accept, rd_done;
   logic               we_sel, ctl_sel;
   logic [ADDR_W-1:0]  addr_sel;
   logic [DATA_W-1:0]  wdata_sel, rd_data;

   always_ff @(posedge clk or negedge NRST) begin
      if (!NRST) state_q <= StIdle;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (accept) state_d = StIssue;
         StIssue:  state_d = we_q ? StIdle : StRdWait;
         StRdWait: if (rd_done) state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Ready is gated by NRST so nothing is granted while reset is held.
   always_comb begin
      gnt         = (req_valid_0 & req_valid_1) ? prio_q : req_valid_1;
      accept      = NRST & (state_q == StIdle) & (req_valid_0 | req_valid_1);
      req_ready_0 = accept & ~gnt;
      req_ready_1 = accept & gnt;
      we_sel      = gnt ? req_we_1    : req_we_0;
      ctl_sel     = gnt ? req_ctl_1   : req_ctl_0;
      addr_sel    = gnt ? req_addr_1  : req_addr_0;
      wdata_sel   = gnt ? req_wdata_1 : req_wdata_0;
      rd_done     = (state_q == StRdWait) && (cnt_q == CNT_W'(1));
      rd_data     = ctl_q ? ctl_dout : ram_dout;
   end

   // Bus outputs are loaded on accept so they are driven for exactly the ISSUE cycle.
   always_ff @(posedge clk or negedge NRST) begin
      if (!NRST) begin
         prio_q      <= 1'b0;
         gnt_q       <= 1'b0;
         we_q        <= 1'b0;
         ctl_q       <= 1'b0;
         cnt_q       <= '0;
         sel_ram     <= 1'b0;
         sel_ctl     <= 1'b0;
         we          <= 1'b0;
         addr        <= '0;
         din         <= '0;
         rsp_valid_0 <= 1'b0;
         rsp_valid_1 <= 1'b0;
         rsp_data_0  <= '0;
         rsp_data_1  <= '0;
      end else begin
         sel_ram <= accept & ~ctl_sel;
         sel_ctl <= accept & ctl_sel;
         we      <= accept & we_sel;
         addr    <= accept ? addr_sel : '0;
         din     <= accept ? wdata_sel : '0;
         if (accept) begin
            prio_q <= ~gnt;
            gnt_q  <= gnt;
            we_q   <= we_sel;
            ctl_q  <= ctl_sel;
         end
         if (state_q == StIssue)       cnt_q <= CNT_W'(RD_LAT);
         else if (state_q == StRdWait) cnt_q <= cnt_q - CNT_W'(1);
         rsp_valid_0 <= rd_done & ~gnt_q;
         rsp_valid_1 <= rd_done & gnt_q;
         if (rd_done & ~gnt_q) rsp_data_0 <= rd_data;
         if (rd_done & gnt_q)  rsp_data_1 <= rd_data;
      end
   end

endmodule

// File: tb/tb_video_bus_arb.sv
// Bench for video_bus_arb: vector table, directed corner sequences on RD_LAT=1 and
// RD_LAT=3 instances, and random traffic against a timeline reference model.
module tb_video_bus_arb;
   localparam int AW = 13;
   localparam int DW = 8;
   localparam int RL = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic nrst, nrst3;
   logic [1:0] rv, rwe, rctl, rdy, rspv;
   logic [1:0][AW-1:0] raddr;
   logic [1:0][DW-1:0] rwd, rspd;
   logic sel_ram, sel_ctl, we;
   logic [AW-1:0] addr;
   logic [DW-1:0] din, ram_dout, ctl_dout;

   logic [1:0] rv3, rwe3, rctl3, rdy3, rspv3;
   logic [1:0][AW-1:0] raddr3;
   logic [1:0][DW-1:0] rwd3, rspd3;
   logic sel_ram3, sel_ctl3, we3;
   logic [AW-1:0] addr3;
   logic [DW-1:0] din3, ram_dout3, ctl_dout3;

   video_bus_arb #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL)) u_dut (
      .clk(clk), .NRST(nrst),
      .req_valid_0(rv[0]), .req_ready_0(rdy[0]), .req_we_0(rwe[0]), .req_ctl_0(rctl[0]),
      .req_addr_0(raddr[0]), .req_wdata_0(rwd[0]), .rsp_valid_0(rspv[0]), .rsp_data_0(rspd[0]),
      .req_valid_1(rv[1]), .req_ready_1(rdy[1]), .req_we_1(rwe[1]), .req_ctl_1(rctl[1]),
      .req_addr_1(raddr[1]), .req_wdata_1(rwd[1]), .rsp_valid_1(rspv[1]), .rsp_data_1(rspd[1]),
      .sel_ram(sel_ram), .sel_ctl(sel_ctl), .we(we), .addr(addr), .din(din),
      .ram_dout(ram_dout), .ctl_dout(ctl_dout)
   );

   video_bus_arb #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) u_dut3 (
      .clk(clk), .NRST(nrst3),
      .req_valid_0(rv3[0]), .req_ready_0(rdy3[0]), .req_we_0(rwe3[0]), .req_ctl_0(rctl3[0]),
      .req_addr_0(raddr3[0]), .req_wdata_0(rwd3[0]), .rsp_valid_0(rspv3[0]),
      .rsp_data_0(rspd3[0]),
      .req_valid_1(rv3[1]), .req_ready_1(rdy3[1]), .req_we_1(rwe3[1]), .req_ctl_1(rctl3[1]),
      .req_addr_1(raddr3[1]), .req_wdata_1(rwd3[1]), .rsp_valid_1(rspv3[1]),
      .rsp_data_1(rspd3[1]),
      .sel_ram(sel_ram3), .sel_ctl(sel_ctl3), .we(we3), .addr(addr3), .din(din3),
      .ram_dout(ram_dout3), .ctl_dout(ctl_dout3)
   );

   typedef struct {
      logic [1:0]    v;
      logic [1:0]    ctl;
      logic [AW-1:0] a0, a1;
      logic [DW-1:0] d0, d1;
      logic [1:0]    rdy;
      logic          sr, sc;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", n, act, exp, $time);
      end
   endtask

   task automatic chk_bus(input string n, input logic sr, input logic sc, input logic w,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
      chk({n, ".sel_ram"}, 32'(sel_ram), 32'(sr));
      chk({n, ".sel_ctl"}, 32'(sel_ctl), 32'(sc));
      chk({n, ".we"}, 32'(we), 32'(w));
      chk({n, ".addr"}, 32'(addr), 32'(a));
      chk({n, ".din"}, 32'(din), 32'(d));
   endtask

   task automatic chk_bus3(input string n, input logic sr, input logic sc, input logic w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
      chk({n, ".sel_ram"}, 32'(sel_ram3), 32'(sr));
      chk({n, ".sel_ctl"}, 32'(sel_ctl3), 32'(sc));
      chk({n, ".we"}, 32'(we3), 32'(w));
      chk({n, ".addr"}, 32'(addr3), 32'(a));
      chk({n, ".din"}, 32'(din3), 32'(d));
   endtask

   task automatic chk_zero(input string n);
      chk({n, ".ready"}, 32'(rdy), 32'd0);
      chk({n, ".rsp_valid"}, 32'(rspv), 32'd0);
      chk({n, ".rsp_data"}, 32'(rspd), 32'd0);
      chk_bus(n, 1'b0, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic chk_zero3(input string n);
      chk({n, ".ready"}, 32'(rdy3), 32'd0);
      chk({n, ".rsp_valid"}, 32'(rspv3), 32'd0);
      chk({n, ".rsp_data"}, 32'(rspd3), 32'd0);
      chk_bus3(n, 1'b0, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic rst_dut();
      rv   = '0;
      nrst = 1'b0;
      repeat (2) nxt();
      nrst = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int n[2];
      int gc[2];
      int eg, lg;
      int next_free, rsp_cyc, rsp_port, g;
      bit prio_m, rsp_pend, rsp_ctl_m;
      logic [DW-1:0] cap;
      logic [1:0][DW-1:0] last;
      logic [1:0] pend, erdy, erspv;
      logic esr, esc, ewe;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;

      nrst = 1'b1; nrst3 = 1'b1;
      rv = '0; rwe = '0; rctl = '0; raddr = '0; rwd = '0; ram_dout = '0; ctl_dout = '0;
      rv3 = '0; rwe3 = '0; rctl3 = '0; raddr3 = '0; rwd3 = '0; ram_dout3 = '0; ctl_dout3 = '0;
      #1;
      nrst = 1'b0; nrst3 = 1'b0;

      // Reset held with both requesters valid: nothing granted, all outputs 0.
      rv = 2'b11; rwe = 2'b11; rctl = 2'b00;
      raddr[0] = 13'h0042; raddr[1] = 13'h0043; rwd[0] = 8'h42; rwd[1] = 8'h43;
      for (int i = 0; i < 3; i++) begin
         nxt(); #1;
         chk_zero("reset");
      end
      nxt(); nrst = 1'b1; #1;
      chk("reset.first_grant", 32'(rdy), 32'd1);
      nxt(); rv = '0; #1;
      chk_bus("reset.first_access", 1'b1, 1'b0, 1'b1, 13'h0042, 8'h42);

      // Vector table: one write per entry, grant then bus access.
      vecs[0] = '{2'b11, 2'b00, 13'h0001, 13'h0002, 8'h11, 8'h22, 2'b01, 1'b1, 1'b0, 13'h0001, 8'h11};
      vecs[1] = '{2'b11, 2'b10, 13'h0003, 13'h1FFF, 8'h33, 8'hFF, 2'b10, 1'b0, 1'b1, 13'h1FFF, 8'hFF};
      vecs[2] = '{2'b10, 2'b00, 13'h0004, 13'h0ABC, 8'h44, 8'h5A, 2'b10, 1'b1, 1'b0, 13'h0ABC, 8'h5A};
      vecs[3] = '{2'b11, 2'b01, 13'h0000, 13'h0555, 8'h00, 8'h55, 2'b01, 1'b0, 1'b1, 13'h0000, 8'h00};
      vecs[4] = '{2'b01, 2'b00, 13'h1234, 13'h0666, 8'hC3, 8'h66, 2'b01, 1'b1, 1'b0, 13'h1234, 8'hC3};
      vecs[5] = '{2'b11, 2'b00, 13'h0007, 13'h0800, 8'h07, 8'h80, 2'b10, 1'b1, 1'b0, 13'h0800, 8'h80};
      vecs[6] = '{2'b00, 2'b11, 13'h1111, 13'h1222, 8'hAA, 8'hBB, 2'b00, 1'b0, 1'b0, 13'h0000, 8'h00};
      vecs[7] = '{2'b11, 2'b00, 13'h0FED, 13'h0DEF, 8'h12, 8'h34, 2'b01, 1'b1, 1'b0, 13'h0FED, 8'h12};
      rst_dut();
      for (int i = 0; i < 8; i++) begin
         nxt();
         rv = vecs[i].v; rwe = 2'b11; rctl = vecs[i].ctl;
         raddr[0] = vecs[i].a0; raddr[1] = vecs[i].a1; rwd[0] = vecs[i].d0; rwd[1] = vecs[i].d1;
         #1;
         chk($sformatf("vec%0d.ready", i), 32'(rdy), 32'(vecs[i].rdy));
         nxt(); rv = '0; #1;
         chk_bus($sformatf("vec%0d", i), vecs[i].sr, vecs[i].sc, |vecs[i].rdy, vecs[i].ea,
                 vecs[i].ed);
      end

      // Single write from port 1.
      nxt(); rv = 2'b10; rwe[1] = 1'b1; rctl[1] = 1'b0; raddr[1] = 13'h0123; rwd[1] = 8'hA5;
      #1; chk("wr1.ready", 32'(rdy), 32'd2);
      nxt(); rv = '0; #1; chk_bus("wr1.access", 1'b1, 1'b0, 1'b1, 13'h0123, 8'hA5);
      nxt(); #1; chk_bus("wr1.after", 1'b0, 1'b0, 1'b0, '0, '0);

      // Control read from port 0, RD_LAT=1.
      ctl_dout = 8'h3C; ram_dout = 8'h99;
      nxt(); rv = 2'b01; rwe[0] = 1'b0; rctl[0] = 1'b1; raddr[0] = 13'h0004; rwd[0] = 8'h00;
      #1; chk("rd0.ready", 32'(rdy), 32'd1);
      nxt(); rv = '0; #1; chk_bus("rd0.access", 1'b0, 1'b1, 1'b0, 13'h0004, 8'h00);
      nxt(); #1; chk("rd0.wait_rsp", 32'(rspv), 32'd0);
      nxt(); #1;
      chk("rd0.rsp_valid", 32'(rspv), 32'd1);
      chk("rd0.rsp_data", 32'(rspd[0]), 32'h3C);
      nxt(); #1;
      chk("rd0.rsp_pulse", 32'(rspv), 32'd0);
      chk("rd0.rsp_hold", 32'(rspd[0]), 32'h3C);

      // Both ports streaming writes: strict alternation, one access per 2 cycles.
      rst_dut();
      n = '{0, 0}; gc = '{0, 0}; lg = 0;
      for (int i = 0; i < 200; i++) begin
         nxt();
         rv = 2'b11; rwe = 2'b11; rctl = 2'b00;
         raddr[0] = AW'(n[0]); raddr[1] = AW'(32'h1000 + 32'(n[1]));
         rwd[0] = DW'(n[0]); rwd[1] = DW'(32'h80 + 32'(n[1]));
         #1;
         if (i % 2 == 0) begin
            eg = (i / 2) % 2;
            chk("stream.ready", 32'(rdy), (eg == 1) ? 32'd2 : 32'd1);
            if (rdy == 2'b01) gc[0]++;
            else if (rdy == 2'b10) gc[1]++;
            lg = eg;
         end else begin
            chk("stream.idle_ready", 32'(rdy), 32'd0);
            chk_bus("stream", 1'b1, 1'b0, 1'b1, raddr[lg], rwd[lg]);
            n[lg]++;
         end
      end
      rv = '0;
      chk("stream.grants0", 32'(gc[0]), 32'd50);
      chk("stream.grants1", 32'(gc[1]), 32'd50);

      // Random traffic against a timeline model: bus free at next_free, response at T+2+L.
      rst_dut();
      pend = '0; last = '0; cap = '0; next_free = 0; prio_m = 1'b0; rsp_pend = 1'b0;
      rsp_cyc = 0; rsp_port = 0; rsp_ctl_m = 1'b0;
      esr = 1'b0; esc = 1'b0; ewe = 1'b0; ea = '0; ed = '0;
      for (int c = 0; c < 1500; c++) begin
         nxt();
         for (int p = 0; p < 2; p++) begin
            if (!pend[p] && $urandom_range(0, 99) < 55) begin
               pend[p]  = 1'b1;
               rwe[p]   = 1'($urandom_range(0, 1));
               rctl[p]  = 1'($urandom_range(0, 1));
               raddr[p] = AW'($urandom());
               rwd[p]   = DW'($urandom());
            end
         end
         rv = pend;
         ram_dout = DW'($urandom());
         ctl_dout = DW'($urandom());
         #1;
         erdy = '0; g = -1;
         if (c >= next_free && rv != 2'b00) begin
            g = (rv == 2'b11) ? int'(prio_m) : (rv[1] ? 1 : 0);
            erdy[g] = 1'b1;
         end
         chk("rnd.ready", 32'(rdy), 32'(erdy));
         chk_bus("rnd", esr, esc, ewe, ea, ed);
         erspv = '0;
         if (rsp_pend && c == rsp_cyc) begin
            erspv[rsp_port] = 1'b1;
            last[rsp_port]  = cap;
            rsp_pend        = 1'b0;
         end
         chk("rnd.rsp_valid", 32'(rspv), 32'(erspv));
         chk("rnd.rsp_data0", 32'(rspd[0]), 32'(last[0]));
         chk("rnd.rsp_data1", 32'(rspd[1]), 32'(last[1]));
         if (rsp_pend && c == rsp_cyc - 1) cap = rsp_ctl_m ? ctl_dout : ram_dout;
         esr = 1'b0; esc = 1'b0; ewe = 1'b0; ea = '0; ed = '0;
         if (g >= 0) begin
            esr = ~rctl[g]; esc = rctl[g]; ewe = rwe[g]; ea = raddr[g]; ed = rwd[g];
            prio_m = (g == 0);
            next_free = c + (rwe[g] ? 2 : 2 + RL);
            if (!rwe[g]) begin
               rsp_pend  = 1'b1;
               rsp_cyc   = c + 2 + RL;
               rsp_port  = g;
               rsp_ctl_m = rctl[g];
            end
            pend[g] = 1'b0;
         end
      end
      rv = '0;

      // RD_LAT=3: VRAM read on port 0 with a write queued on port 1 behind it.
      nxt(); nrst3 = 1'b1;
      nxt(); rv3 = 2'b01; rwe3[0] = 1'b0; rctl3[0] = 1'b0; raddr3[0] = 13'h0055;
      rwd3[0] = 8'h00; ram_dout3 = 8'h70;
      #1; chk("lat3.ready_rd", 32'(rdy3), 32'd1);
      nxt(); rv3 = 2'b10; rwe3[1] = 1'b1; rctl3[1] = 1'b0; raddr3[1] = 13'h0ABC;
      rwd3[1] = 8'h66; ram_dout3 = 8'h71;
      #1;
      chk("lat3.issue_ready", 32'(rdy3), 32'd0);
      chk_bus3("lat3.rd_access", 1'b1, 1'b0, 1'b0, 13'h0055, 8'h00);
      for (int k = 2; k <= 4; k++) begin
         nxt(); ram_dout3 = DW'(8'h70 + k); #1;
         chk("lat3.wait_ready", 32'(rdy3), 32'd0);
         chk("lat3.wait_rsp", 32'(rspv3), 32'd0);
      end
      nxt(); ram_dout3 = 8'h75; #1;
      chk("lat3.rsp_valid", 32'(rspv3), 32'd1);
      chk("lat3.rsp_data", 32'(rspd3[0]), 32'h74);
      chk("lat3.queued_ready", 32'(rdy3), 32'd2);
      nxt(); rv3 = '0; #1;
      chk_bus3("lat3.wr_access", 1'b1, 1'b0, 1'b1, 13'h0ABC, 8'h66);
      chk("lat3.rsp_pulse", 32'(rspv3), 32'd0);

      // Reset asserted during RDWAIT abandons the read.
      nxt(); rv3 = 2'b01; rwe3[0] = 1'b0; rctl3[0] = 1'b1; raddr3[0] = 13'h0007;
      ctl_dout3 = 8'h5E;
      #1; chk("rstmid.ready", 32'(rdy3), 32'd1);
      nxt(); rv3 = '0; #1; chk_bus3("rstmid.access", 1'b0, 1'b1, 1'b0, 13'h0007, 8'h00);
      nxt();
      rv3 = 2'b11; rwe3 = 2'b11; rctl3 = 2'b00;
      raddr3[0] = 13'h0100; raddr3[1] = 13'h0200; rwd3[0] = 8'h01; rwd3[1] = 8'h02;
      nrst3 = 1'b0;
      #1; chk_zero3("rstmid.now");
      for (int i = 0; i < 2; i++) begin
         nxt(); #1; chk_zero3("rstmid.held");
      end
      nxt(); nrst3 = 1'b1; rv3 = '0;
      for (int i = 0; i < 6; i++) begin
         #1; chk("rstmid.no_rsp", 32'(rspv3), 32'd0);
         nxt();
      end
      rv3 = 2'b11; #1;
      chk("rstmid.after_ready", 32'(rdy3), 32'd1);
      nxt(); rv3 = '0; #1;
      chk_bus3("rstmid.after_access", 1'b1, 1'b0, 1'b1, 13'h0100, 8'h01);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
